rf_wr_ctrl: RTL



---
 rtl/rf_wr_ctrl_if.sv | 43 ++++
 rtl/rf_wr_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/rf_wr_ctrl_if.sv
// Regfile write-port bus: writeback, LSU and debug requesters plus regfile drive and status.
interface rf_wr_ctrl_if;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic              wb_en_i;
  logic [REG_W-1:0]  wb_reg_i;
  logic [DATA_W-1:0] wb_data_i;

  logic              lsu_valid_i;
  logic [REG_W-1:0]  lsu_reg_i;
  logic [DATA_W-1:0] lsu_data_i;
  logic              lsu_ready_o;

  logic              dbg_valid_i;
  logic [REG_W-1:0]  dbg_reg_i;
  logic [DATA_W-1:0] dbg_data_i;
  logic              dbg_ready_o;

  logic              w_en_rf_o;
  logic [REG_W-1:0]  w_reg_rf_o;
  logic [DATA_W-1:0] w_data_rf_o;
  logic              init_busy_o;
  logic              wb_drop_o;

  // Requester / observer side
  modport master (
    output wb_en_i, wb_reg_i, wb_data_i,
    output lsu_valid_i, lsu_reg_i, lsu_data_i,
    output dbg_valid_i, dbg_reg_i, dbg_data_i,
    input  lsu_ready_o, dbg_ready_o,
    input  w_en_rf_o, w_reg_rf_o, w_data_rf_o, init_busy_o, wb_drop_o
  );

  // Controller side
  modport slave (
    input  wb_en_i, wb_reg_i, wb_data_i,
    input  lsu_valid_i, lsu_reg_i, lsu_data_i,
    input  dbg_valid_i, dbg_reg_i, dbg_data_i,
    output lsu_ready_o, dbg_ready_o,
    output w_en_rf_o, w_reg_rf_o, w_data_rf_o, init_busy_o, wb_drop_o
  );
endinterface

// File: rtl/rf_wr_ctrl.sv
// Regfile write-port controller: zero-fills all registers after reset, then
// arbitrates wb > starved dbg > lsu > dbg onto the single write port.
module rf_wr_ctrl #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic         clk,
  input  logic         reset,
  rf_wr_ctrl_if.slave  bus
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [REG_W-1:0] LAST_REG = REG_W'(31);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [REG_W-1:0]  fill_cnt;
  logic [CNT_W-1:0]  dbg_wait;
  logic              wb_drop_q;
  logic              w_en_q;
  logic [REG_W-1:0]  w_reg_q;
  logic [DATA_W-1:0] w_data_q;

  logic in_run;
  logic dbg_starved;
  logic grant_wb;
  logic grant_lsu;
  logic grant_dbg;

  // Combinational grant; a reset cycle never accepts a request
  always_comb begin
    in_run      = (state == RUN) && !reset;
    dbg_starved = bus.dbg_valid_i && (dbg_wait == WAIT_MAX);
    grant_wb    = in_run && bus.wb_en_i;
    grant_lsu   = in_run && !bus.wb_en_i && !dbg_starved && bus.lsu_valid_i;
    grant_dbg   = in_run && !bus.wb_en_i && bus.dbg_valid_i &&
                  (dbg_starved || !bus.lsu_valid_i);
  end

  // FSM, fill sequencer, debug wait counter and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      fill_cnt  <= '0;
      dbg_wait  <= '0;
      wb_drop_q <= 1'b0;
      w_en_q    <= 1'b0;
      w_reg_q   <= '0;
      w_data_q  <= '0;
    end else begin
      case (state)
        INIT: begin
          w_en_q   <= 1'b1;
          w_reg_q  <= fill_cnt;
          w_data_q <= '0;
          fill_cnt <= fill_cnt + REG_W'(1);
          if (bus.wb_en_i) wb_drop_q <= 1'b1;
          if (fill_cnt == LAST_REG) state <= RUN;
        end
        RUN: begin
          // x0 writes are consumed but never reach the regfile
          if (grant_wb) begin
            w_en_q <= (bus.wb_reg_i != '0);
            if (bus.wb_reg_i != '0) begin
              w_reg_q  <= bus.wb_reg_i;
              w_data_q <= bus.wb_data_i;
            end
          end else if (grant_lsu) begin
            w_en_q <= (bus.lsu_reg_i != '0);
            if (bus.lsu_reg_i != '0) begin
              w_reg_q  <= bus.lsu_reg_i;
              w_data_q <= bus.lsu_data_i;
            end
          end else if (grant_dbg) begin
            w_en_q <= (bus.dbg_reg_i != '0);
            if (bus.dbg_reg_i != '0) begin
              w_reg_q  <= bus.dbg_reg_i;
              w_data_q <= bus.dbg_data_i;
            end
          end else begin
            w_en_q <= 1'b0;
          end

          if (!bus.dbg_valid_i || grant_dbg) begin
            dbg_wait <= '0;
          end else if (dbg_wait != WAIT_MAX) begin
            dbg_wait <= dbg_wait + CNT_W'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Output drive
  assign bus.lsu_ready_o = grant_lsu;
  assign bus.dbg_ready_o = grant_dbg;
  assign bus.w_en_rf_o   = w_en_q;
  assign bus.w_reg_rf_o  = w_reg_q;
  assign bus.w_data_rf_o = w_data_q;
  assign bus.init_busy_o = (state == INIT);
  assign bus.wb_drop_o   = wb_drop_q;

endmodule
